// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - pipeline stage register with 2-entry skid buffer, flush and stall counter
module pipe_skid_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] main_pc, main_pc_nxt, skid_pc, skid_pc_nxt;
  logic [DATA_W-1:0] main_inst, main_inst_nxt, skid_inst, skid_inst_nxt;
  logic              in_fire, out_fire;

  // Handshake flags come from registered state only, so no combinational
  // path exists from out_ready to in_ready or from in_* to out_*.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != SKID);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Main is already zeroed whenever the stage empties; the gate keeps the
  // nop-on-invalid guarantee independent of that bookkeeping.
  assign out_pc   = out_valid ? main_pc   : '0;
  assign out_inst = out_valid ? main_inst : '0;

  // Next-state and storage update; flush overrides every handshake outcome.
  always_comb begin
    state_nxt     = state;
    main_pc_nxt   = main_pc;
    main_inst_nxt = main_inst;
    skid_pc_nxt   = skid_pc;
    skid_inst_nxt = skid_inst;
    if (flush) begin
      state_nxt     = EMPTY;
      main_pc_nxt   = '0;
      main_inst_nxt = '0;
      skid_pc_nxt   = '0;
      skid_inst_nxt = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt     = FULL;
            main_pc_nxt   = in_pc;
            main_inst_nxt = in_inst;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_pc_nxt   = in_pc;
            main_inst_nxt = in_inst;
          end else if (in_fire) begin
            state_nxt     = SKID;
            skid_pc_nxt   = in_pc;
            skid_inst_nxt = in_inst;
          end else if (out_fire) begin
            state_nxt     = EMPTY;
            main_pc_nxt   = '0;
            main_inst_nxt = '0;
          end
        end
        SKID: begin
          if (out_fire) begin
            state_nxt     = FULL;
            main_pc_nxt   = skid_pc;
            main_inst_nxt = skid_inst;
            skid_pc_nxt   = '0;
            skid_inst_nxt = '0;
          end
        end
        default: begin
          state_nxt     = EMPTY;
          main_pc_nxt   = '0;
          main_inst_nxt = '0;
          skid_pc_nxt   = '0;
          skid_inst_nxt = '0;
        end
      endcase
    end
  end

  // State and storage registers; reset drops any held entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_pc   <= '0;
      main_inst <= '0;
      skid_pc   <= '0;
      skid_inst <= '0;
    end else begin
      state     <= state_nxt;
      main_pc   <= main_pc_nxt;
      main_inst <= main_inst_nxt;
      skid_pc   <= skid_pc_nxt;
      skid_inst <= skid_inst_nxt;
    end
  end

  // Saturating count of cycles where downstream refuses valid data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg against a queue model
module tb_pipe_skid_reg;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush;
  logic [31:0] in_pc, in_inst;
  logic        in_ready, out_valid, in_ready3, out_valid3;
  logic [31:0] out_pc, out_inst, out_pc3, out_inst3;
  logic [15:0] stall16;
  logic [2:0]  stall3;

  int          errors = 0;
  int          checks = 0;
  ent_t        q[$];
  int          cnt;
  logic [31:0] next_pc;

  always #5 clk = ~clk;

  pipe_skid_reg u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .flush(flush), .stall_cycles(stall16)
  );

  pipe_skid_reg #(.CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid3), .out_ready(out_ready),
    .out_pc(out_pc3), .out_inst(out_inst3), .flush(flush), .stall_cycles(stall3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the contents of the model queue alone.
  task automatic check_outputs();
    logic        ev;
    logic [31:0] epc, einst;
    ev    = (q.size() > 0);
    epc   = ev ? q[0].pc : 32'h0;
    einst = ev ? q[0].inst : 32'h0;
    chk("out_valid", {63'h0, out_valid}, {63'h0, ev});
    chk("in_ready", {63'h0, in_ready}, {63'h0, (q.size() < 2)});
    chk("out_pc", {32'h0, out_pc}, {32'h0, epc});
    chk("out_inst", {32'h0, out_inst}, {32'h0, einst});
    chk("stall16", {48'h0, stall16}, cnt);
    chk("stall3", {61'h0, stall3}, (cnt > 7) ? 7 : cnt);
    chk("out_pc3", {32'h0, out_pc3}, {32'h0, epc});
  endtask

  // Model step: a FIFO of depth 2; flush empties it after any delivery.
  task automatic model_step(output logic accepted);
    logic ofire, ifire;
    ofire = (q.size() > 0) && out_ready;
    ifire = in_valid && (q.size() < 2);
    accepted = ifire && !flush;
    if ((q.size() > 0) && !out_ready) cnt++;
    if (flush) begin
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back('{pc: in_pc, inst: in_inst});
    end
  endtask

  // One clock: entered and left 1 time unit after a rising edge.
  task automatic cycle();
    logic acc;
    #3;
    check_outputs();
    model_step(acc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = '0; in_inst = '0;
    q.delete();
    cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic ordy);
    in_valid = 1'b1; in_pc = pc; in_inst = pc ^ 32'hA5A5_0000; out_ready = ordy;
  endtask

  initial begin
    logic acc;
    do_reset();
    check_outputs();

    // Back-to-back stream with no backpressure.
    offer(32'h100, 1'b1); cycle();
    chk("stream_first_pc", {32'h0, out_pc}, 64'h100);
    offer(32'h104, 1'b1); cycle();
    offer(32'h108, 1'b1); cycle();
    chk("stream_third_pc", {32'h0, out_pc}, 64'h108);
    in_valid = 1'b0; cycle();
    chk("stream_stall", {48'h0, stall16}, 64'h0);
    cycle();

    // Skid fill then drain.
    do_reset();
    offer(32'h200, 1'b1); cycle();
    offer(32'h204, 1'b0); cycle();
    chk("skid_in_ready", {63'h0, in_ready}, 64'h0);
    chk("skid_out_pc", {32'h0, out_pc}, 64'h200);
    in_valid = 1'b0; out_ready = 1'b1; cycle();
    chk("drain_in_ready", {63'h0, in_ready}, 64'h1);
    chk("drain_out_pc", {32'h0, out_pc}, 64'h204);
    cycle();
    cycle();

    // Flush while both entries are held; the offered 0x308 must vanish.
    do_reset();
    offer(32'h300, 1'b0); cycle();
    offer(32'h304, 1'b0); cycle();
    offer(32'h308, 1'b0); flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", {63'h0, out_valid}, 64'h0);
    chk("flush_out_pc", {32'h0, out_pc}, 64'h0);
    chk("flush_out_inst", {32'h0, out_inst}, 64'h0);
    chk("flush_in_ready", {63'h0, in_ready}, 64'h1);
    cycle(); cycle();

    // Stall counter, including saturation of the narrow instance.
    do_reset();
    offer(32'h400, 1'b0); cycle();
    in_valid = 1'b0;
    repeat (5) cycle();
    chk("stall_5", {48'h0, stall16}, 64'd5);
    repeat (5) cycle();
    chk("stall_10", {48'h0, stall16}, 64'd10);
    chk("stall_sat", {61'h0, stall3}, 64'd7);

    // Asynchronous reset between edges while in SKID.
    offer(32'h500, 1'b0); cycle();
    chk("pre_reset_in_ready", {63'h0, in_ready}, 64'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("arst_out_pc", {32'h0, out_pc}, 64'h0);
    chk("arst_out_inst", {32'h0, out_inst}, 64'h0);
    chk("arst_stall", {48'h0, stall16}, 64'h0);
    chk("arst_in_ready", {63'h0, in_ready}, 64'h1);
    q.delete();
    cnt = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic; upstream holds its offer until accepted.
    next_pc = 32'h1000;
    in_pc = next_pc; in_inst = $urandom;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #3;
      check_outputs();
      model_step(acc);
      @(posedge clk);
      #1;
      if (acc) begin
        next_pc = next_pc + 32'd4;
        in_pc   = next_pc;
        in_inst = $urandom;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    chk("final_empty", {32'h0, q.size()}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
